// File: rtl/regfile_wr_arb_if.sv
// Register-file write arbiter bus: two writeback requesters plus the write port.
interface regfile_wr_arb_if #(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned ADDR_W = 5
);
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [WIDTH-1:0]  req0_data;
    logic              req0_ready;

    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic [WIDTH-1:0]  req1_data;
    logic              req1_ready;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;

    // Arbiter side
    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready,
        output wr_en, wr_addr, wr_data
    );

    // Requester / register-file side
    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready,
        input  wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/regfile_wr_arb.sv
// Round-robin arbiter for the single register-file write port (ALU vs load).
// Optional contention counter enabled with macro RFARB_STATS_EN.

// Variable-width enabled DFF with synchronous active-high reset.
module regfile_wr_arb_dff #(
    parameter int unsigned   W       = 1,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    // Capture on enable, reset wins
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_q <= RST_VAL;
        end else if (i_en) begin
            o_q <= i_d;
        end
    end
endmodule

module regfile_wr_arb #(
    parameter int unsigned WIDTH    = 64,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 31
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    regfile_wr_arb_if.slave     bus,
    output logic [15:0]         conflict_cnt
);
    localparam int unsigned CNT_W = 16;

    logic              w_grant0;
    logic              w_grant1;
    logic              w_xfer;
    logic              w_contend;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [WIDTH-1:0]  w_sel_data;
    logic              w_wr_en_d;

    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [WIDTH-1:0]  r_wr_data;
    logic              r_last_grant;   // 1: req1 was granted most recently

    // Grant selection: single valid wins; on contention the one not granted last
    always_comb begin
        w_grant0   = 1'b0;
        w_grant1   = 1'b0;
        w_contend  = bus.req0_valid & bus.req1_valid;
        if (!reset && !flush) begin
            w_grant0 = bus.req0_valid & (!bus.req1_valid | r_last_grant);
            w_grant1 = bus.req1_valid & (!bus.req0_valid | !r_last_grant);
        end
        w_xfer     = w_grant0 | w_grant1;
        w_sel_addr = w_grant1 ? bus.req1_addr : bus.req0_addr;
        w_sel_data = w_grant1 ? bus.req1_data : bus.req0_data;
        // Writes to the zero register are accepted but never reach the file
        w_wr_en_d  = w_xfer & (w_sel_addr != ADDR_W'(ZERO_REG));
    end

    assign bus.req0_ready = w_grant0;
    assign bus.req1_ready = w_grant1;

    regfile_wr_arb_dff #(.W(1), .RST_VAL(1'b0)) u_wr_en (
        .i_clk(clk), .i_reset(reset), .i_en(1'b1), .i_d(w_wr_en_d), .o_q(r_wr_en)
    );

    regfile_wr_arb_dff #(.W(ADDR_W), .RST_VAL('0)) u_wr_addr (
        .i_clk(clk), .i_reset(reset), .i_en(w_xfer), .i_d(w_sel_addr), .o_q(r_wr_addr)
    );

    regfile_wr_arb_dff #(.W(WIDTH), .RST_VAL('0)) u_wr_data (
        .i_clk(clk), .i_reset(reset), .i_en(w_xfer), .i_d(w_sel_data), .o_q(r_wr_data)
    );

    // Reset value 1 lets req0 win the first contention
    regfile_wr_arb_dff #(.W(1), .RST_VAL(1'b1)) u_last_grant (
        .i_clk(clk), .i_reset(reset), .i_en(w_xfer), .i_d(w_grant1), .o_q(r_last_grant)
    );

    assign bus.wr_en   = r_wr_en;
    assign bus.wr_addr = r_wr_addr;
    assign bus.wr_data = r_wr_data;

`ifdef RFARB_STATS_EN
    logic [CNT_W-1:0] r_conflict_cnt;

    // Saturating count of cycles where both requesters contend
    always_ff @(posedge clk) begin
        if (reset) begin
            r_conflict_cnt <= '0;
        end else if (w_contend && !flush && (r_conflict_cnt != {CNT_W{1'b1}})) begin
            r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
        end
    end

    assign conflict_cnt = r_conflict_cnt;
`else
    logic w_unused_contend;
    assign w_unused_contend = w_contend;
    assign conflict_cnt     = CNT_W'(0);
`endif
endmodule
